// File: rtl/uart_cmd_parser_if.sv
// Byte-stream interface between the CDC buffer and the UART command parser.
// The master side drives the buffered frame bytes and observes the parser
// results; the slave side is the parser itself.
interface uart_cmd_parser_if #(
    parameter int P_CNT_WIDTH = 16
);
    logic [7:0]             i_pre_data;
    logic [7:0]             i_pre_len;
    logic                   i_pre_last;
    logic                   i_pre_valid;

    logic [7:0]             o_cmd;
    logic [7:0]             o_len;
    logic [7:0]             o_payload_data;
    logic                   o_payload_valid;
    logic                   o_payload_last;
    logic                   o_frame_done;
    logic                   o_frame_err;
    logic [2:0]             o_err_code;
    logic [P_CNT_WIDTH-1:0] o_good_cnt;
    logic [P_CNT_WIDTH-1:0] o_err_cnt;

    modport master (
        output i_pre_data, i_pre_len, i_pre_last, i_pre_valid,
        input  o_cmd, o_len, o_payload_data, o_payload_valid, o_payload_last,
               o_frame_done, o_frame_err, o_err_code, o_good_cnt, o_err_cnt
    );

    modport slave (
        input  i_pre_data, i_pre_len, i_pre_last, i_pre_valid,
        output o_cmd, o_len, o_payload_data, o_payload_valid, o_payload_last,
               o_frame_done, o_frame_err, o_err_code, o_good_cnt, o_err_cnt
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART DMA frame parser: header, command, length, payload.
// Validates framing, forwards payload speculatively (commit on o_frame_done,
// discard on o_frame_err) and keeps saturating good/error frame counters.
// Optional macro UART_CMD_CHKSUM_EN: each frame carries a trailing checksum
// byte equal to the mod-256 sum of cmd, len and all payload bytes.
module uart_cmd_parser #(
    parameter logic [7:0] P_HEADER    = 8'h55,
    parameter int         P_MAX_LEN   = 255,
    parameter int         P_CNT_WIDTH = 16
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_cmd_parser_if.slave bus
);

    localparam logic [2:0] ERR_BAD_HDR = 3'd1;
    localparam logic [2:0] ERR_SHORT   = 3'd2;
    localparam logic [2:0] ERR_LONG    = 3'd3;
    localparam logic [2:0] ERR_BAD_LEN = 3'd4;
`ifdef UART_CMD_CHKSUM_EN
    localparam logic [2:0] ERR_CHKSUM  = 3'd5;
`endif
    localparam logic [8:0] MAX_LEN9    = 9'(P_MAX_LEN);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        DROP = 3'd4
`ifdef UART_CMD_CHKSUM_EN
        ,
        CHK  = 3'd5
`endif
    } state_t;

    state_t                 state_q;
    logic [7:0]             byteCnt_q;
    logic [7:0]             byteCnt_d;
    logic [7:0]             cmd_q;
    logic [7:0]             len_q;
    logic [7:0]             payloadData_q;
    logic                   payloadValid_q;
    logic                   payloadLast_q;
    logic                   frameDone_q;
    logic                   frameErr_q;
    logic [2:0]             errCode_q;
    logic [P_CNT_WIDTH-1:0] goodCnt_q;
    logic [P_CNT_WIDTH-1:0] errCnt_q;
    logic                   lenBad;
    logic                   unusedPreLen;

    // The buffer's own length field is informational; the parser trusts the in-band length byte.
    assign unusedPreLen = ^bus.i_pre_len;

    assign byteCnt_d = byteCnt_q + 8'd1;
    assign lenBad    = (bus.i_pre_data == 8'd0) || ({1'b0, bus.i_pre_data} > MAX_LEN9);

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;

    assign sum_d = sum_q + bus.i_pre_data;
`endif

    // Frame state machine; payload strobes and done/err pulses are registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            byteCnt_q      <= 8'd0;
            cmd_q          <= 8'd0;
            len_q          <= 8'd0;
            payloadData_q  <= 8'd0;
            payloadValid_q <= 1'b0;
            payloadLast_q  <= 1'b0;
            frameDone_q    <= 1'b0;
            frameErr_q     <= 1'b0;
            errCode_q      <= 3'd0;
`ifdef UART_CMD_CHKSUM_EN
            sum_q          <= 8'd0;
`endif
        end else begin
            payloadValid_q <= 1'b0;
            payloadLast_q  <= 1'b0;
            frameDone_q    <= 1'b0;
            frameErr_q     <= 1'b0;
            if (bus.i_pre_valid) begin
                case (state_q)
                    IDLE: begin
                        if (bus.i_pre_data == P_HEADER) begin
                            if (bus.i_pre_last) begin
                                frameErr_q <= 1'b1;
                                errCode_q  <= ERR_SHORT;
                            end else begin
                                state_q <= CMD;
                            end
                        end else begin
                            frameErr_q <= 1'b1;
                            errCode_q  <= ERR_BAD_HDR;
                            if (!bus.i_pre_last) begin
                                state_q <= DROP;
                            end
                        end
                    end
                    CMD: begin
                        cmd_q <= bus.i_pre_data;
`ifdef UART_CMD_CHKSUM_EN
                        sum_q <= bus.i_pre_data;
`endif
                        if (bus.i_pre_last) begin
                            frameErr_q <= 1'b1;
                            errCode_q  <= ERR_SHORT;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= LEN;
                        end
                    end
                    LEN: begin
                        len_q     <= bus.i_pre_data;
                        byteCnt_q <= 8'd0;
`ifdef UART_CMD_CHKSUM_EN
                        sum_q     <= sum_d;
`endif
                        if (lenBad) begin
                            frameErr_q <= 1'b1;
                            errCode_q  <= ERR_BAD_LEN;
                            state_q    <= bus.i_pre_last ? IDLE : DROP;
                        end else if (bus.i_pre_last) begin
                            frameErr_q <= 1'b1;
                            errCode_q  <= ERR_SHORT;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        byteCnt_q      <= byteCnt_d;
                        payloadData_q  <= bus.i_pre_data;
                        payloadValid_q <= 1'b1;
                        payloadLast_q  <= (byteCnt_d == len_q);
`ifdef UART_CMD_CHKSUM_EN
                        sum_q          <= sum_d;
                        if (byteCnt_d == len_q) begin
                            if (bus.i_pre_last) begin
                                frameErr_q <= 1'b1;
                                errCode_q  <= ERR_SHORT;
                                state_q    <= IDLE;
                            end else begin
                                state_q <= CHK;
                            end
                        end else if (bus.i_pre_last) begin
                            frameErr_q <= 1'b1;
                            errCode_q  <= ERR_SHORT;
                            state_q    <= IDLE;
                        end
`else
                        if (byteCnt_d == len_q) begin
                            if (bus.i_pre_last) begin
                                frameDone_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                frameErr_q <= 1'b1;
                                errCode_q  <= ERR_LONG;
                                state_q    <= DROP;
                            end
                        end else if (bus.i_pre_last) begin
                            frameErr_q <= 1'b1;
                            errCode_q  <= ERR_SHORT;
                            state_q    <= IDLE;
                        end
`endif
                    end
`ifdef UART_CMD_CHKSUM_EN
                    CHK: begin
                        // A checksum byte that is not the frame end means extra trailing bytes.
                        if (!bus.i_pre_last) begin
                            frameErr_q <= 1'b1;
                            errCode_q  <= ERR_LONG;
                            state_q    <= DROP;
                        end else if (bus.i_pre_data != sum_q) begin
                            frameErr_q <= 1'b1;
                            errCode_q  <= ERR_CHKSUM;
                            state_q    <= IDLE;
                        end else begin
                            frameDone_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
`endif
                    DROP: begin
                        if (bus.i_pre_last) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating frame counters, stepped by the registered done/err pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            goodCnt_q <= '0;
            errCnt_q  <= '0;
        end else begin
            if (frameDone_q && (goodCnt_q != '1)) begin
                goodCnt_q <= goodCnt_q + 1'b1;
            end
            if (frameErr_q && (errCnt_q != '1)) begin
                errCnt_q <= errCnt_q + 1'b1;
            end
        end
    end

    assign bus.o_cmd           = cmd_q;
    assign bus.o_len           = len_q;
    assign bus.o_payload_data  = payloadData_q;
    assign bus.o_payload_valid = payloadValid_q;
    assign bus.o_payload_last  = payloadLast_q;
    assign bus.o_frame_done    = frameDone_q;
    assign bus.o_frame_err     = frameErr_q;
    assign bus.o_err_code      = errCode_q;
    assign bus.o_good_cnt      = goodCnt_q;
    assign bus.o_err_cnt       = errCnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser.
// Expected payload/done/err events are queued as frames are driven and
// popped by a monitor sampling on the falling clock edge.
module tb_uart_cmd_parser;

    localparam int CW = 4;

    localparam logic [1:0] K_PAY  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       last;
        logic [2:0] code;
    } evt_t;

    logic i_clk;
    logic i_rst;
    int   compared;
    int   mismatched;
    evt_t expQ[$];

    uart_cmd_parser_if #(.P_CNT_WIDTH(CW)) bus ();

    uart_cmd_parser #(
        .P_HEADER   (8'h55),
        .P_MAX_LEN  (255),
        .P_CNT_WIDTH(CW)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic evt_t mkEvt(input logic [1:0] kind, input logic [7:0] data,
                                   input logic last, input logic [2:0] code);
        evt_t e;
        e.kind = kind;
        e.data = data;
        e.last = last;
        e.code = code;
        return e;
    endfunction

    task automatic compareEvt(input string tag, input evt_t obs);
        evt_t exp;
        if (expQ.size() == 0) begin
            checkOutput({tag, "Unexpected"}, 32'(obs), 32'd0);
        end else begin
            exp = expQ.pop_front();
            checkOutput(tag, 32'(obs), 32'(exp));
        end
    endtask

    task automatic expectPayload(input logic [7:0] d, input logic last);
        expQ.push_back(mkEvt(K_PAY, d, last, 3'd0));
    endtask

    task automatic expectDone();
        expQ.push_back(mkEvt(K_DONE, 8'd0, 1'b0, 3'd0));
    endtask

    task automatic expectErr(input logic [2:0] code);
        expQ.push_back(mkEvt(K_ERR, 8'd0, 1'b0, code));
    endtask

    // Output monitor: every strobe seen on the falling edge must match the queue head.
    always @(negedge i_clk) begin
        if (bus.o_payload_valid) begin
            compareEvt("payload", mkEvt(K_PAY, bus.o_payload_data, bus.o_payload_last, 3'd0));
        end
        if (bus.o_frame_done) begin
            compareEvt("done", mkEvt(K_DONE, 8'd0, 1'b0, 3'd0));
        end
        if (bus.o_frame_err) begin
            compareEvt("err", mkEvt(K_ERR, 8'd0, 1'b0, bus.o_err_code));
        end
        if (bus.o_frame_done || bus.o_frame_err) begin
            checkOutput("doneErrExclusive", 32'(bus.o_frame_done & bus.o_frame_err), 32'd0);
        end
        if (!bus.o_payload_valid && bus.o_payload_last) begin
            checkOutput("lastWithoutValid", 32'd1, 32'd0);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
        end
        #1;
    endtask

    task automatic applyReset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Drive a byte sequence; optional one-cycle gap after every second byte.
    task automatic applyStimulus(input logic [7:0] b[$], input bit withGaps, input bit markLast);
        for (int i = 0; i < b.size(); i++) begin
            @(posedge i_clk);
            #1;
            bus.i_pre_valid = 1'b1;
            bus.i_pre_data  = b[i];
            bus.i_pre_len   = 8'(b.size());
            bus.i_pre_last  = markLast && (i == b.size() - 1);
            if (withGaps && (i % 2 == 1)) begin
                @(posedge i_clk);
                #1;
                bus.i_pre_valid = 1'b0;
                bus.i_pre_last  = 1'b0;
                bus.i_pre_data  = 8'hEE;
            end
        end
        @(posedge i_clk);
        #1;
        bus.i_pre_valid = 1'b0;
        bus.i_pre_last  = 1'b0;
    endtask

    // Well-formed frame: queues payload + done, appends checksum when that build is selected.
    task automatic sendGood(input logic [7:0] cmd, input logic [7:0] pl[$], input bit withGaps);
        logic [7:0] f[$];
        logic [7:0] sum;
        f   = {8'h55, cmd, 8'(pl.size())};
        sum = cmd + 8'(pl.size());
        for (int i = 0; i < pl.size(); i++) begin
            f.push_back(pl[i]);
            sum = sum + pl[i];
            expectPayload(pl[i], i == pl.size() - 1);
        end
`ifdef UART_CMD_CHKSUM_EN
        f.push_back(sum);
`endif
        expectDone();
        applyStimulus(f, withGaps, 1'b1);
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        i_rst           = 1'b1;
        bus.i_pre_valid = 1'b0;
        bus.i_pre_data  = 8'h00;
        bus.i_pre_len   = 8'h00;
        bus.i_pre_last  = 1'b0;
        idle(3);
        i_rst = 1'b0;
        idle(1);

        $display("[TB] reset state");
        checkOutput("rstCmd", 32'(bus.o_cmd), 32'd0);
        checkOutput("rstLen", 32'(bus.o_len), 32'd0);
        checkOutput("rstErrCode", 32'(bus.o_err_code), 32'd0);
        checkOutput("rstGood", 32'(bus.o_good_cnt), 32'd0);
        checkOutput("rstErrCnt", 32'(bus.o_err_cnt), 32'd0);
        checkOutput("rstPayValid", 32'(bus.o_payload_valid), 32'd0);
        checkOutput("rstDone", 32'(bus.o_frame_done), 32'd0);

        $display("[TB] single good frame");
        sendGood(8'h01, '{8'h66}, 1'b0);
        idle(3);
        checkOutput("f1Cmd", 32'(bus.o_cmd), 32'h01);
        checkOutput("f1Len", 32'(bus.o_len), 32'h01);
        checkOutput("f1Good", 32'(bus.o_good_cnt), 32'd1);

        $display("[TB] five back-to-back frames");
        applyReset();
        for (int k = 1; k <= 5; k++) begin
            sendGood(8'(k), '{8'(8'h10 + k), 8'(8'h20 + k)}, k[0]);
        end
        idle(3);
        checkOutput("fiveGood", 32'(bus.o_good_cnt), 32'd5);
        checkOutput("fiveErr", 32'(bus.o_err_cnt), 32'd0);
        checkOutput("fiveCmd", 32'(bus.o_cmd), 32'd5);

        $display("[TB] bad header then good frame");
        expectErr(3'd1);
        applyStimulus('{8'h56, 8'h01, 8'h01, 8'h66}, 1'b0, 1'b1);
        idle(3);
        checkOutput("badHdrCode", 32'(bus.o_err_code), 32'd1);
        checkOutput("badHdrCnt", 32'(bus.o_err_cnt), 32'd1);
        sendGood(8'h02, '{8'hAA, 8'hBB}, 1'b0);
        idle(3);
        checkOutput("abCmd", 32'(bus.o_cmd), 32'h02);
        checkOutput("abGood", 32'(bus.o_good_cnt), 32'd6);

        $display("[TB] short frame");
        expectPayload(8'h11, 1'b0);
        expectPayload(8'h22, 1'b0);
        expectErr(3'd2);
        applyStimulus('{8'h55, 8'h01, 8'h03, 8'h11, 8'h22}, 1'b0, 1'b1);
        idle(3);
        checkOutput("shortCode", 32'(bus.o_err_code), 32'd2);
        checkOutput("shortCnt", 32'(bus.o_err_cnt), 32'd2);

        $display("[TB] long frame");
        expectPayload(8'h77, 1'b1);
        expectErr(3'd3);
`ifdef UART_CMD_CHKSUM_EN
        applyStimulus('{8'h55, 8'h01, 8'h01, 8'h77, 8'h79, 8'h88}, 1'b0, 1'b1);
`else
        applyStimulus('{8'h55, 8'h01, 8'h01, 8'h77, 8'h88}, 1'b0, 1'b1);
`endif
        idle(3);
        checkOutput("longCode", 32'(bus.o_err_code), 32'd3);
        checkOutput("longCnt", 32'(bus.o_err_cnt), 32'd3);

        $display("[TB] zero length");
        expectErr(3'd4);
        applyStimulus('{8'h55, 8'h01, 8'h00, 8'h12}, 1'b0, 1'b1);
        idle(3);
        checkOutput("zeroLen", 32'(bus.o_len), 32'd0);
        checkOutput("badLenCode", 32'(bus.o_err_code), 32'd4);
        checkOutput("badLenCnt", 32'(bus.o_err_cnt), 32'd4);

        $display("[TB] error counter saturation");
        for (int k = 0; k < 14; k++) begin
            expectErr(3'd1);
            applyStimulus('{8'h00}, 1'b0, 1'b1);
        end
        idle(3);
        checkOutput("errSat", 32'(bus.o_err_cnt), 32'd15);
        checkOutput("goodHeld", 32'(bus.o_good_cnt), 32'd6);

        $display("[TB] reset mid-frame");
        applyStimulus('{8'h55, 8'h01}, 1'b0, 1'b0);
        applyReset();
        idle(1);
        checkOutput("midRstCmd", 32'(bus.o_cmd), 32'd0);
        checkOutput("midRstErrCnt", 32'(bus.o_err_cnt), 32'd0);
        checkOutput("midRstGood", 32'(bus.o_good_cnt), 32'd0);
        checkOutput("midRstCode", 32'(bus.o_err_code), 32'd0);
        expectErr(3'd1);
        applyStimulus('{8'h01, 8'h66}, 1'b0, 1'b1);
        idle(3);
        checkOutput("tailCode", 32'(bus.o_err_code), 32'd1);
        checkOutput("tailCnt", 32'(bus.o_err_cnt), 32'd1);

`ifdef UART_CMD_CHKSUM_EN
        $display("[TB] checksum frames");
        expectPayload(8'h77, 1'b1);
        expectDone();
        applyStimulus('{8'h55, 8'h01, 8'h01, 8'h77, 8'h79}, 1'b0, 1'b1);
        idle(3);
        checkOutput("chkGood", 32'(bus.o_good_cnt), 32'd1);
        expectPayload(8'h77, 1'b1);
        expectErr(3'd5);
        applyStimulus('{8'h55, 8'h01, 8'h01, 8'h77, 8'h78}, 1'b0, 1'b1);
        idle(3);
        checkOutput("chkCode", 32'(bus.o_err_code), 32'd5);
        checkOutput("chkErrCnt", 32'(bus.o_err_cnt), 32'd2);
`endif

        idle(2);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Frame parser sitting in the system clock domain, directly downstream of the Data_Mclk_buf clock-crossing buffer.
- Consumes the byte stream of received UART DMA frames: header 0x55, command, length, payload.
- Validates framing and extracts command and payload for downstream register/control logic.
- Reports per-frame done/error pulses and keeps good/error frame counters.

Parameters:
- P_HEADER, 8'h55, required first byte of every frame.
- P_MAX_LEN, 255, maximum accepted payload length (1..255).
- P_CNT_WIDTH, 16, width of the good/error frame counters.

Ports:
- i_clk  input  1  system clock; single clock domain.
- i_rst  input  1  synchronous, active-high reset.
- i_pre_data  input  8  frame byte from the CDC buffer.
- i_pre_len  input  8  buffer frame length; informational only, ignored by the parser.
- i_pre_last  input  1  marks the final byte of a buffered frame.
- i_pre_valid  input  1  byte strobe. No backpressure: the parser accepts every valid byte.
- o_cmd  output  8  command byte of the current/last frame; held until the next CMD capture.
- o_len  output  8  length byte of the current/last frame; held.
- o_payload_data  output  8  payload byte.
- o_payload_valid  output  1  payload strobe.
- o_payload_last  output  1  final payload byte (byte index == o_len).
- o_frame_done  output  1  1-cycle pulse: frame fully valid.
- o_frame_err  output  1  1-cycle pulse: frame rejected.
- o_err_code  output  3  cause of the most recent error; held.
- o_good_cnt  output  P_CNT_WIDTH  count of done frames; saturating.
- o_err_cnt  output  P_CNT_WIDTH  count of error frames; saturating.

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0.
- Registered outputs: o_payload_*, o_frame_done and o_frame_err update 1 cycle after the input byte that causes them.
- Input bytes with i_pre_valid=0 are ignored; gaps are allowed at any point in a frame.
- States: IDLE, CMD, LEN, DATA, DROP (plus CHK when the optional feature is compiled in).
- IDLE, valid byte:
  - byte == P_HEADER and not last -> CMD.
  - byte == P_HEADER and last -> err 2 (SHORT), stay IDLE.
  - byte != P_HEADER -> err 1 (BAD_HDR); go to DROP if not last, else stay IDLE.
- CMD, valid byte: capture o_cmd. If last -> err 2, IDLE; else -> LEN.
- LEN, valid byte: capture o_len; clear counter.
  - len == 0 or len > P_MAX_LEN -> err 4 (BAD_LEN); DROP if not last, else IDLE.
  - else if last -> err 2, IDLE.
  - else -> DATA.
- DATA, valid byte: counter increments (8-bit, 1..len); forward byte with o_payload_valid=1; o_payload_last=1 when counter == len.
  - counter == len and last -> o_frame_done, IDLE.
  - counter == len and not last -> err 3 (LONG) in the same cycle as o_payload_last, then DROP.
  - counter < len and last -> err 2 (SHORT), IDLE; o_payload_last stays 0.
- DROP: consume bytes silently; on a valid last byte -> IDLE. No pulse is generated on exit.
- Payload is forwarded speculatively. Consumers must commit only on o_frame_done; o_frame_err means discard.
- Exactly one done or err pulse per frame. Never both in the same cycle.
- Counters: +1 per done/err pulse; saturate at all-ones, no wrap.
- Reset asserted mid-frame: the parser returns to IDLE; later bytes of that frame are parsed from IDLE and produce BAD_HDR.

Optional Feature:
- Macro UART_CMD_CHKSUM_EN.
- Defined: each frame carries one trailing checksum byte = 8-bit sum (mod 256) of cmd, len and all payload bytes.
  - DATA: counter == len and not last -> CHK. counter == len and last -> err 2.
  - CHK, valid byte: mismatch -> err 5 (CHKSUM); match -> o_frame_done. If that byte is not last -> err 3, DROP.
  - o_payload_last still marks the final payload byte; done/err follows on the checksum byte.
- Undefined: no CHK state, no checksum logic; err code 5 never occurs.

Test Plan:
- Bytes 55,01,01,66 (last on 66) -> o_cmd=01, one payload 66 with valid+last, o_frame_done pulse, o_good_cnt=1.
- Five such frames back-to-back, including single-cycle gaps -> 5 done pulses, o_good_cnt=5, o_err_cnt=0.
- Frame 56,01,01,66 -> err pulse, o_err_code=1, no payload output; next frame 55,02,02,AA,BB -> done, payload AA,BB.
- Frame 55,01,03,11,22 (last on 22) -> payloads 11,22 with no payload_last, err code 2; frame 55,01,01,77,88 -> payload_last on 77, err code 3 in the same cycle, 88 dropped.
- Frame 55,01,00,.. -> err code 4. Force o_err_cnt to all-ones, send a bad frame -> count holds. Assert i_rst after the 55,01 bytes -> outputs cleared; the following 01,66 -> BAD_HDR.
- Checksum build only: frame 55,01,01,77,79 -> done; same frame with checksum 78 -> err code 5.
